window_minmax_tracker: RTL and testbench
========================================

Name: window_minmax_tracker

Overview:
Downstream consumer of the 4-bit magnitude comparator stage. It accepts a stream of unsigned samples and tracks the running maximum, running minimum and the number of samples equal to the current maximum over a fixed window of WINDOW samples. At the end of each window it presents one result record on a valid/ready output port. The per-sample magnitude decisions (A>B, A<B, A==B) come from the comparator sub-module.

Parameters:
WIDTH, 4, sample width in bits (unsigned).
WINDOW, 8, samples per window; legal range 2..255.
CNT_W, 8, width of the tie and sample counters; must satisfy 2^CNT_W > WINDOW.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst_n  input  1  reset, synchronous, active-low.
clear  input  1  synchronous abort: discards the partial window and returns to IDLE.
in_valid  input  1  sample valid.
in_ready  output  1  block can accept a sample this cycle.
in_data  input  WIDTH  sample value.
out_valid  output  1  result record valid.
out_ready  input  1  downstream accepts the record.
out_max  output  WIDTH  maximum sample in the window.
out_min  output  WIDTH  minimum sample in the window.
out_max_cnt  output  CNT_W  number of samples in the window equal to out_max.

Behaviour:
- Input transfer occurs when in_valid && in_ready at a rising clk edge. Output transfer occurs when out_valid && out_ready.
- Reset (rst_n=0 sampled at a clk edge):
  - in_ready=0 during the reset cycle, 1 on the first cycle after reset releases.
  - out_valid=0, out_max=0, out_min=0, out_max_cnt=0.
  - State is IDLE; sample counter is 0.
- The FSM has three states: IDLE, ACCUM and HOLD.
- IDLE: in_ready=1.
  - On transfer: max<=in_data, min<=in_data, max_cnt<=1, cnt<=1.
  - Go to ACCUM.
- ACCUM: in_ready=1.
  - On transfer, compare in_data against max:
    - greater: max<=in_data, max_cnt<=1.
    - equal: max_cnt<=max_cnt+1.
    - less: no change to max.
  - Independently, compare in_data against min: if less, min<=in_data.
  - cnt<=cnt+1.
  - When the accepted sample is the WINDOW-th: latch max, min and max_cnt onto the outputs, assert out_valid next cycle, go to HOLD.
- HOLD: in_ready=0; out_valid=1; outputs stay stable until transfer.
  - On transfer: out_valid<=0 and go to IDLE. in_ready returns to 1 on the following cycle.
  - No bypass: there is one bubble cycle per window.
- Latency: out_valid rises exactly 1 cycle after the WINDOW-th sample is accepted.
- Outputs are held (not cleared) after a handshake until the next record is latched. out_valid alone qualifies them.
- clear:
  - Sampled in any state; forces IDLE, out_valid<=0 and cnt<=0. Data outputs keep their last value.
  - If clear and an input transfer coincide, the sample is dropped.
  - If clear and an output transfer coincide, the record counts as consumed.
- Priority: rst_n > clear > handshake.
- Stall tolerance: in_valid low for any number of cycles within ACCUM leaves all state unchanged.
- Boundaries:
  - All samples equal gives max==min and max_cnt=WINDOW.
  - All-zero and all-ones windows must work without wrap.
  - max_cnt cannot overflow given the CNT_W rule.
- All arithmetic is unsigned at WIDTH bits. Counters are CNT_W bits and never wrap inside a window.

Decomposition:
- Shared package (window_minmax_pkg):
  - FSM state encoding: IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2.
  - Default WIDTH/WINDOW/CNT_W constants.
  - A record typedef {max, min, max_cnt}.
- One sub-module, mag_compare: purely combinational, WIDTH-parameterised, outputs gt/lt/eq (exactly one high).
  - Instantiated twice: in_data vs max, and in_data vs min.
- The FSM, registers and handshake live in the top module.

Test Plan:
1. Reset then a stream of 3,7,1,7,0,7,2,5 with out_ready=1 -> one cycle after the 8th accept, out_valid=1 with max=7, min=0, max_cnt=3. in_ready=0 for exactly that one cycle.
2. Eight samples of 4'hA -> max=A, min=A, max_cnt=8.
3. Window of 0..7 with out_ready held 0 for 5 cycles -> out_valid and outputs stable for all 5 cycles, in_ready=0 throughout. A sample of 9 offered during the stall is not accepted. After out_ready=1, a new window starts from 9.
4. Samples F,0,F,0 then clear together with in_valid=1 (sample 3), then 2,2,2,2,2,2,2,2 -> the first result is max=2, min=2, max_cnt=8 (partial window and sample 3 discarded).
5. rst_n=0 asserted while in HOLD with out_ready=0 -> next cycle out_valid=0 and outputs 0. After release, in_ready=1 and the next window is counted from 1.
6. Random in_valid gaps (30% idle) over 20 windows checked against a scoreboard max/min/tie model -> every record matches, and no sample is lost or double-counted.

Source files
------------

// File: rtl/window_minmax_tracker_pkg.sv
// Shared types and default constants for the window min/max tracker.
package window_minmax_pkg;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_WINDOW = 8;
   localparam int DEF_CNT_W  = 8;

   // Control states of the window tracker.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // One result record at the default widths.
   typedef struct packed {
      logic [DEF_WIDTH-1:0] max;
      logic [DEF_WIDTH-1:0] min;
      logic [DEF_CNT_W-1:0] max_cnt;
   } rec_t;

endpackage

// File: rtl/window_minmax_tracker_if.sv
// Sample-in / record-out handshake bundle for window_minmax_tracker.
// The master side is the producer/consumer environment, the slave side the tracker.
interface window_minmax_tracker_if
   import window_minmax_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
);

   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_max;
   logic [WIDTH-1:0] out_min;
   logic [CNT_W-1:0] out_max_cnt;

   modport master (
      output clear,
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_max,
      input  out_min,
      input  out_max_cnt
   );

   modport slave (
      input  clear,
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_max,
      output out_min,
      output out_max_cnt
   );

endinterface

// File: rtl/window_minmax_tracker_mag_compare.sv
// Unsigned magnitude comparator: exactly one of gt/lt/eq is high.
module mag_compare #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gt,
   output logic             lt,
   output logic             eq
);

   // Pure combinational decision on a versus b.
   always_comb begin
      gt = (a > b);
      lt = (a < b);
      eq = (a == b);
   end

endmodule

// File: rtl/window_minmax_tracker.sv
// Tracks max, min and the count of samples equal to the max over windows of
// WINDOW samples and emits one record per window on a valid/ready port.
module window_minmax_tracker
   import window_minmax_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int WINDOW = DEF_WINDOW,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   window_minmax_tracker_if.slave  bus
);

   // Index of the last sample of a window, expressed at counter width.
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

   typedef struct packed {
      logic [WIDTH-1:0] max;
      logic [WIDTH-1:0] min;
      logic [CNT_W-1:0] max_cnt;
   } win_rec_t;

   state_t           state_reg,     state_next;
   logic [WIDTH-1:0] max_reg,       max_next;
   logic [WIDTH-1:0] min_reg,       min_next;
   logic [CNT_W-1:0] max_cnt_reg,   max_cnt_next;
   logic [CNT_W-1:0] cnt_reg,       cnt_next;
   win_rec_t         out_rec_reg,   out_rec_next;
   logic             out_valid_reg, out_valid_next;
   logic             in_ready_reg;

   logic in_fire;
   logic out_fire;

   // Comparator lane 0 checks the sample against the running max,
   // lane 1 against the running min.
   logic [WIDTH-1:0] cmp_ref [2];
   logic             cmp_gt  [2];
   logic             cmp_lt  [2];
   logic             cmp_eq  [2];
   logic             unused_cmp;

   assign cmp_ref[0] = max_reg;
   assign cmp_ref[1] = min_reg;

   for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
      mag_compare #(
         .WIDTH (WIDTH)
      ) u_cmp (
         .a  (bus.in_data),
         .b  (cmp_ref[gi]),
         .gt (cmp_gt[gi]),
         .lt (cmp_lt[gi]),
         .eq (cmp_eq[gi])
      );
   end

   // A smaller sample leaves the max alone, and only "less" matters for the min.
   assign unused_cmp = ^{cmp_lt[0], cmp_gt[1], cmp_eq[1]};

   assign in_fire  = bus.in_valid && in_ready_reg;
   assign out_fire = out_valid_reg && bus.out_ready;

   // Next-state, accumulator and record-latch logic.
   always_comb begin
      state_next     = state_reg;
      max_next       = max_reg;
      min_next       = min_reg;
      max_cnt_next   = max_cnt_reg;
      cnt_next       = cnt_reg;
      out_rec_next   = out_rec_reg;
      out_valid_next = out_valid_reg;

      if (bus.clear) begin
         // Abort wins over both handshakes; data outputs keep their value.
         state_next     = IDLE;
         out_valid_next = 1'b0;
         cnt_next       = '0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (in_fire) begin
                  max_next     = bus.in_data;
                  min_next     = bus.in_data;
                  max_cnt_next = CNT_W'(1);
                  cnt_next     = CNT_W'(1);
                  state_next   = ACCUM;
               end
            end
            ACCUM: begin
               if (in_fire) begin
                  if (cmp_gt[0]) begin
                     max_next     = bus.in_data;
                     max_cnt_next = CNT_W'(1);
                  end else if (cmp_eq[0]) begin
                     max_cnt_next = max_cnt_reg + CNT_W'(1);
                  end
                  if (cmp_lt[1]) begin
                     min_next = bus.in_data;
                  end
                  cnt_next = cnt_reg + CNT_W'(1);
                  if (cnt_reg == LAST_IDX) begin
                     out_rec_next.max     = max_next;
                     out_rec_next.min     = min_next;
                     out_rec_next.max_cnt = max_cnt_next;
                     out_valid_next       = 1'b1;
                     state_next           = HOLD;
                  end
               end
            end
            HOLD: begin
               if (out_fire) begin
                  out_valid_next = 1'b0;
                  state_next     = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers; in_ready is registered so it is low
   // throughout reset and rises on the first cycle after release.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         max_reg       <= '0;
         min_reg       <= '0;
         max_cnt_reg   <= '0;
         cnt_reg       <= '0;
         out_rec_reg   <= '0;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         max_reg       <= max_next;
         min_reg       <= min_next;
         max_cnt_reg   <= max_cnt_next;
         cnt_reg       <= cnt_next;
         out_rec_reg   <= out_rec_next;
         out_valid_reg <= out_valid_next;
         in_ready_reg  <= (state_next != HOLD);
      end
   end

   assign bus.in_ready    = in_ready_reg;
   assign bus.out_valid   = out_valid_reg;
   assign bus.out_max     = out_rec_reg.max;
   assign bus.out_min     = out_rec_reg.min;
   assign bus.out_max_cnt = out_rec_reg.max_cnt;

endmodule

// File: tb/tb_window_minmax_tracker.sv
// Directed and scoreboard-checked bench for window_minmax_tracker (WINDOW=8).
module tb_window_minmax_tracker;
   import window_minmax_pkg::*;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   window_minmax_tracker_if #(.WIDTH(4), .CNT_W(8)) dut_if ();

   window_minmax_tracker #(
      .WIDTH  (4),
      .WINDOW (8),
      .CNT_W  (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dut_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offer one sample until it is accepted; returns #1 after the accepting edge.
   task automatic send(input logic [3:0] v);
      logic acc;
      logic ok;
      ok = 1'b0;
      dut_if.in_valid = 1'b1;
      dut_if.in_data  = v;
      for (int k = 0; k < 20; k++) begin
         acc = dut_if.in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            ok = 1'b1;
            break;
         end
      end
      dut_if.in_valid = 1'b0;
      n_assert++;
      if (!ok) begin
         n_fail++;
         $display("FAIL send_timeout: sample %0h not accepted within 20 cycles", v);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      dut_if.clear     = 1'b0;
      dut_if.in_valid  = 1'b0;
      dut_if.in_data   = '0;
      dut_if.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_assert++;
      if (dut_if.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL rst_in_ready: got %b expected 0", dut_if.in_ready);
      end
      n_assert++;
      if (dut_if.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_out_valid: got %b expected 0", dut_if.out_valid);
      end
      n_assert++;
      if ({dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt} !== 16'h0000) begin
         n_fail++; $display("FAIL rst_outputs: got %h/%h/%0d expected 0/0/0",
                            dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_assert++;
      if (dut_if.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_release_ready: got %b expected 1", dut_if.in_ready);
      end
      $display("reset done");
   endtask

   task automatic test_basic_window;
      logic [3:0] vec [8];
      vec = '{4'd3, 4'd7, 4'd1, 4'd7, 4'd0, 4'd7, 4'd2, 4'd5};
      dut_if.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send(vec[i]);
         if (i == 6) begin
            n_assert++;
            if (dut_if.out_valid !== 1'b0) begin
               n_fail++; $display("FAIL basic_early_valid: got %b expected 0", dut_if.out_valid);
            end
         end
      end
      n_assert++;
      if (dut_if.out_valid !== 1'b1) begin
         n_fail++; $display("FAIL basic_valid: got %b expected 1", dut_if.out_valid);
      end
      n_assert++;
      if (dut_if.out_max !== 4'd7 || dut_if.out_min !== 4'd0 || dut_if.out_max_cnt !== 8'd3) begin
         n_fail++; $display("FAIL basic_record: got %h/%h/%0d expected 7/0/3",
                            dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt);
      end
      n_assert++;
      if (dut_if.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL basic_bubble: in_ready got %b expected 0", dut_if.in_ready);
      end
      $display("record max=%h min=%h cnt=%0d", dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt);
      @(posedge clk);
      #1;
      n_assert++;
      if (dut_if.out_valid !== 1'b0 || dut_if.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL basic_after: valid/ready got %b/%b expected 0/1",
                            dut_if.out_valid, dut_if.in_ready);
      end
      n_assert++;
      if (dut_if.out_max !== 4'd7 || dut_if.out_min !== 4'd0 || dut_if.out_max_cnt !== 8'd3) begin
         n_fail++; $display("FAIL basic_held: got %h/%h/%0d expected 7/0/3",
                            dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt);
      end
   endtask

   task automatic test_all_equal;
      dut_if.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) send(4'hA);
      n_assert++;
      if (dut_if.out_valid !== 1'b1 || dut_if.out_max !== 4'hA || dut_if.out_min !== 4'hA
          || dut_if.out_max_cnt !== 8'd8) begin
         n_fail++; $display("FAIL equal_record: got v=%b %h/%h/%0d expected v=1 a/a/8",
                            dut_if.out_valid, dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt);
      end
      $display("record max=%h min=%h cnt=%0d", dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt);
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure;
      logic [3:0] vec [8];
      dut_if.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(4'(i));
      for (int c = 0; c < 5; c++) begin
         dut_if.in_valid = 1'b1;
         dut_if.in_data  = 4'd9;
         n_assert++;
         if (dut_if.out_valid !== 1'b1 || dut_if.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_hs c%0d: valid/ready got %b/%b expected 1/0",
                               c, dut_if.out_valid, dut_if.in_ready);
         end
         n_assert++;
         if (dut_if.out_max !== 4'd7 || dut_if.out_min !== 4'd0 || dut_if.out_max_cnt !== 8'd1) begin
            n_fail++; $display("FAIL stall_data c%0d: got %h/%h/%0d expected 7/0/1",
                               c, dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt);
         end
         @(posedge clk);
         #1;
      end
      $display("record max=%h min=%h cnt=%0d", dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt);
      dut_if.out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_assert++;
      if (dut_if.out_valid !== 1'b0 || dut_if.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL stall_release: valid/ready got %b/%b expected 0/1",
                            dut_if.out_valid, dut_if.in_ready);
      end
      // A 9 accepted during the stall would close this window one sample early.
      vec = '{4'd9, 4'd8, 4'd9, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
      for (int i = 0; i < 8; i++) begin
         send(vec[i]);
         if (i == 6) begin
            n_assert++;
            if (dut_if.out_valid !== 1'b0) begin
               n_fail++; $display("FAIL stall_early_valid: got %b expected 0", dut_if.out_valid);
            end
         end
      end
      n_assert++;
      if (dut_if.out_valid !== 1'b1 || dut_if.out_max !== 4'd9 || dut_if.out_min !== 4'd1
          || dut_if.out_max_cnt !== 8'd2) begin
         n_fail++; $display("FAIL stall_next_record: got v=%b %h/%h/%0d expected v=1 9/1/2",
                            dut_if.out_valid, dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt);
      end
      $display("record max=%h min=%h cnt=%0d", dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt);
      @(posedge clk);
      #1;
   endtask

   task automatic test_clear;
      logic [3:0] vec [4];
      vec = '{4'hF, 4'h0, 4'hF, 4'h0};
      dut_if.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(vec[i]);
      dut_if.in_valid = 1'b1;
      dut_if.in_data  = 4'd3;
      dut_if.clear    = 1'b1;
      @(posedge clk);
      #1;
      dut_if.clear    = 1'b0;
      dut_if.in_valid = 1'b0;
      n_assert++;
      if (dut_if.out_valid !== 1'b0 || dut_if.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL clear_hs: valid/ready got %b/%b expected 0/1",
                            dut_if.out_valid, dut_if.in_ready);
      end
      n_assert++;
      if (dut_if.out_max !== 4'd9 || dut_if.out_min !== 4'd1 || dut_if.out_max_cnt !== 8'd2) begin
         n_fail++; $display("FAIL clear_kept: got %h/%h/%0d expected 9/1/2",
                            dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt);
      end
      for (int i = 0; i < 8; i++) begin
         send(4'd2);
         if (i == 6) begin
            n_assert++;
            if (dut_if.out_valid !== 1'b0) begin
               n_fail++; $display("FAIL clear_early_valid: got %b expected 0", dut_if.out_valid);
            end
         end
      end
      n_assert++;
      if (dut_if.out_valid !== 1'b1 || dut_if.out_max !== 4'd2 || dut_if.out_min !== 4'd2
          || dut_if.out_max_cnt !== 8'd8) begin
         n_fail++; $display("FAIL clear_record: got v=%b %h/%h/%0d expected v=1 2/2/8",
                            dut_if.out_valid, dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt);
      end
      $display("record max=%h min=%h cnt=%0d", dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_in_hold;
      dut_if.out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) send(4'(i));
      n_assert++;
      if (dut_if.out_valid !== 1'b1 || dut_if.out_max !== 4'd8) begin
         n_fail++; $display("FAIL hold_pre: got v=%b max=%h expected v=1 max=8",
                            dut_if.out_valid, dut_if.out_max);
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      n_assert++;
      if (dut_if.out_valid !== 1'b0 || dut_if.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL hold_rst_hs: valid/ready got %b/%b expected 0/0",
                            dut_if.out_valid, dut_if.in_ready);
      end
      n_assert++;
      if ({dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt} !== 16'h0000) begin
         n_fail++; $display("FAIL hold_rst_data: got %h/%h/%0d expected 0/0/0",
                            dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_assert++;
      if (dut_if.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL hold_release_ready: got %b expected 1", dut_if.in_ready);
      end
      dut_if.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         send((i == 7) ? 4'd3 : 4'd4);
         if (i == 6) begin
            n_assert++;
            if (dut_if.out_valid !== 1'b0) begin
               n_fail++; $display("FAIL hold_early_valid: got %b expected 0", dut_if.out_valid);
            end
         end
      end
      n_assert++;
      if (dut_if.out_valid !== 1'b1 || dut_if.out_max !== 4'd4 || dut_if.out_min !== 4'd3
          || dut_if.out_max_cnt !== 8'd7) begin
         n_fail++; $display("FAIL hold_next_record: got v=%b %h/%h/%0d expected v=1 4/3/7",
                            dut_if.out_valid, dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt);
      end
      $display("record max=%h min=%h cnt=%0d", dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt);
      @(posedge clk);
      #1;
   endtask

   task automatic test_random_gaps;
      logic [3:0] v;
      rec_t       exp_rec;
      int         hold;
      dut_if.out_ready = 1'b0;
      exp_rec = '0;
      for (int w = 0; w < 20; w++) begin
         for (int s = 0; s < 8; s++) begin
            if ($urandom_range(0, 9) < 3) begin
               dut_if.in_valid = 1'b0;
               @(posedge clk);
               #1;
            end
            v = 4'($urandom_range(0, 15));
            if (s == 0) begin
               exp_rec.max     = v;
               exp_rec.min     = v;
               exp_rec.max_cnt = 8'd1;
            end else begin
               if (v > exp_rec.max) begin
                  exp_rec.max     = v;
                  exp_rec.max_cnt = 8'd1;
               end else if (v == exp_rec.max) begin
                  exp_rec.max_cnt = exp_rec.max_cnt + 8'd1;
               end
               if (v < exp_rec.min) exp_rec.min = v;
            end
            send(v);
            if (s < 7) begin
               n_assert++;
               if (dut_if.out_valid !== 1'b0) begin
                  n_fail++; $display("FAIL rand_early w%0d s%0d: valid got %b expected 0",
                                     w, s, dut_if.out_valid);
               end
            end
         end
         n_assert++;
         if (dut_if.out_valid !== 1'b1 || dut_if.out_max !== exp_rec.max
             || dut_if.out_min !== exp_rec.min || dut_if.out_max_cnt !== exp_rec.max_cnt) begin
            n_fail++; $display("FAIL rand_record w%0d: got v=%b %h/%h/%0d expected v=1 %h/%h/%0d",
                               w, dut_if.out_valid, dut_if.out_max, dut_if.out_min,
                               dut_if.out_max_cnt, exp_rec.max, exp_rec.min, exp_rec.max_cnt);
         end
         $display("window %0d record max=%h min=%h cnt=%0d", w,
                  dut_if.out_max, dut_if.out_min, dut_if.out_max_cnt);
         hold = $urandom_range(0, 2);
         repeat (hold) @(posedge clk);
         #1;
         dut_if.out_ready = 1'b1;
         @(posedge clk);
         #1;
         dut_if.out_ready = 1'b0;
         n_assert++;
         if (dut_if.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rand_consume w%0d: valid got %b expected 0", w, dut_if.out_valid);
         end
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      test_reset();
      test_basic_window();
      test_all_equal();
      test_backpressure();
      test_clear();
      test_reset_in_hold();
      test_random_gaps();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
